tt_um_reuel_pandher_seq_sched: RTL
==================================

# tt_um_reuel_pandher_seq_sched

Time-multiplexed scheduler sharing one "1101" Moore sequence-detector next-state datapath among four serial input channels. Each channel keeps its own saved 3-bit detector state. A round-robin arbiter grants one pending bit per cycle and steps that channel's state. Per-channel detect pulses and saturating hit counters are exported on the Tiny Tapeout pinout.

## Interface
- NCH, 4, number of channels (fixed by pinout)
- CNT_W, 4, hit-counter width per channel
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock clk
- ena  in  1  ignored
- ui_in  in  8  [3:0] data bit for ch0..ch3; [7:4] req for ch0..ch3
- uio_in  in  8  [5:4] readback channel select; [6] sync clear of all counters; [3:0],[7] unused
- uo_out  out  8  [3:0] detect pulse ch0..ch3; [7:4] hit count of selected channel
- uio_out  out  8  [3:0] grant/ack one-hot ch0..ch3; [7:4] = 0
- uio_oe  out  8  constant 8'h0F

## Operation
- Per-channel state encoding: A=000, B=010, C=110, D=100, E=011.
- Transitions (x = channel data bit):
  - A: x0→A, x1→B
  - B: x0→A, x1→C
  - C: x0→D, x1→C
  - D: x0→A, x1→E
  - E: x0→A, x1→C
  - any other code → A
- Hit = granted channel's next state is E. This detects 1101 with overlap; after E, input 1 goes to C.
- Eligible channels: req[i]=1 and i not acked in the current cycle, i.e. uio_out[i]=0.
- Arbiter: round-robin. Search starts at (last_winner+1) mod 4 and wraps. At most one grant per cycle.
- Grant to channel w at an edge:
  - state[w] ← next(state[w], ui_in[w])
  - last_winner ← w
  - ack[w]=1 for the following cycle
- Ungranted channels hold state. Requests are never lost while req is held.
- Source handshake: hold req and data stable until ack is seen. Update req/data during the ack cycle. The ack mask prevents double consumption.
- On hit for w: detect[w]=1 for the following cycle, and count[w] increments, saturating at 2^CNT_W−1 (15).
- Clear (uio_in[6]=1): all counts ← 0 at the edge. Clear beats a simultaneous increment. Detector states and arbiter are unaffected.
- uo_out[7:4] = count[uio_in[5:4]], combinational mux of registered counters.

## Timing
- Reset values:
  - all states A
  - counts 0
  - uo_out[3:0]=0, uio_out=0
  - last_winner=3, so ch0 has first priority
  - uo_out[7:4]=0
- Reset mid-operation: next edge with rst_n=0 discards all saved states and pending acks. It does not latch a grant.
- Latency:
  - req sampled at edge k
  - ack and detect visible in cycle k..k+1
  - count visible the same cycle as detect
- Throughput:
  - one bit per cycle aggregate
  - a lone requester is served every 2 cycles because of the ack mask
  - 4 saturating requesters are served every 4 cycles each
- Grant, detect and count are registered outputs with no combinational path from ui_in. Only the readback mux is combinational, from uio_in[5:4].

## Structure
- Package seq_sched_pkg holds:
  - state encodings A–E and the 3-bit state type
  - NCH, CNT_W
  - next-state/hit function
- Sub-module rr_arbiter: NCH-wide request and mask inputs, registered last_winner, one-hot grant output.
- Top holds the state array, counters, ack/detect registers and readback mux.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=F → uo_out=00, uio_out=00, uio_oe=0F. The first grant after release goes to ch0.
- Single channel: ch1 presents 1,1,0,1 honoring ack → one detect[1] pulse on the 4th ack and count(sel=1)=1. Continue with 1,0,1 → second hit (overlap), count=2.
- Fairness: req=F held and bits held → ack sequence 0,1,2,3,0,… with no channel acked in two consecutive cycles.
- Interleaving: ch0 sends 1101 while ch2 sends 1100 concurrently → only detect[0] fires. Per-channel states stay independent.
- Saturation and clear: 16 hits on ch3 → count=15, held. A clear asserted on the same edge as a hit → count=0.
- Reset mid-stream: ch0 in state D, assert rst_n=0 for one cycle, then send 1 → no detect. Full 1101 is required afterwards.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared types and the "1101" Moore detector next-state logic for the
// time-multiplexed sequence scheduler.
package seq_sched_pkg;

    localparam int NCH   = 4;
    localparam int CNT_W = 4;
    localparam int IDX_W = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_A = 3'b000,
        ST_B = 3'b010,
        ST_C = 3'b110,
        ST_D = 3'b100,
        ST_E = 3'b011
    } state_t;

    // Unused codes fall back to A so a corrupted saved state self-heals.
    function automatic state_t seq_next(input state_t s, input logic x);
        state_t n;
        case (s)
            ST_A:    n = x ? ST_B : ST_A;
            ST_B:    n = x ? ST_C : ST_A;
            ST_C:    n = x ? ST_C : ST_D;
            ST_D:    n = x ? ST_E : ST_A;
            ST_E:    n = x ? ST_C : ST_A;
            default: n = ST_A;
        endcase
        return n;
    endfunction

    function automatic logic seq_hit(input state_t s, input logic x);
        return (seq_next(s, x) == ST_E);
    endfunction

endpackage

// File: rtl/seq_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible channel after the last winner,
// one grant per cycle; the last winner is held in a register.
module rr_arbiter
    import seq_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   i_req,
    input  logic [NCH-1:0]   i_mask,
    output logic [NCH-1:0]   o_grant,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_last;
    logic [NCH-1:0]   w_elig;
    logic [IDX_W-1:0] w_cand;
    logic             w_take;

    // Rotating priority search; the index wraps naturally with a 2-bit counter.
    always_comb begin
        w_elig  = i_req & ~i_mask;
        w_cand  = '0;
        w_take  = 1'b0;
        o_valid = 1'b0;
        o_idx   = r_last;
        for (int k = 1; k <= NCH; k++) begin
            w_cand  = r_last + IDX_W'(k);
            w_take  = !o_valid && w_elig[w_cand];
            o_idx   = w_take ? w_cand : o_idx;
            o_valid = o_valid | w_take;
        end
        o_grant = o_valid ? (NCH'(1) << o_idx) : '0;
    end

    // Last-winner register; resets to the top channel so ch0 is served first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= IDX_W'(NCH - 1);
        end else if (o_valid) begin
            r_last <= o_idx;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/tt_um_reuel_pandher_seq_sched.sv
// Four serial channels share one "1101" detector datapath; each channel keeps
// its own saved state, and a round-robin arbiter steps one channel per cycle.
module tt_um_reuel_pandher_seq_sched
    import seq_sched_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    state_t           r_state [NCH];
    logic [CNT_W-1:0] r_cnt   [NCH];
    logic [NCH-1:0]   r_ack;
    logic [NCH-1:0]   r_det;

    logic [NCH-1:0]   w_data;
    logic [NCH-1:0]   w_req;
    logic [NCH-1:0]   w_grant;
    logic             w_valid;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_sel;
    logic             w_clr;
    state_t           w_next;
    logic             w_hit;
    logic             w_unused;

    assign w_data   = ui_in[3:0];
    assign w_req    = ui_in[7:4];
    assign w_sel    = uio_in[5:4];
    assign w_clr    = uio_in[6];
    assign w_unused = &{1'b0, ena, uio_in[3:0], uio_in[7]};

    // The ack mask keeps a channel from being consumed twice on one bit.
    rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_req),
        .i_mask  (r_ack),
        .o_grant (w_grant),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // Shared next-state datapath driven by the granted channel.
    always_comb begin
        w_next = seq_next(r_state[w_idx], w_data[w_idx]);
        w_hit  = w_valid && seq_hit(r_state[w_idx], w_data[w_idx]);
    end

    // Channel states, ack/detect pulses and saturating hit counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack <= '0;
            r_det <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= ST_A;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_ack <= w_grant;
            r_det <= w_grant & {NCH{w_hit}};
            if (w_valid) begin
                r_state[w_idx] <= w_next;
            end else begin
                r_state[w_idx] <= r_state[w_idx];
            end
            for (int i = 0; i < NCH; i++) begin
                if (w_clr) begin
                    r_cnt[i] <= '0;
                end else if (w_hit && (w_idx == IDX_W'(i)) && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    assign uo_out  = {r_cnt[w_sel], r_det};
    assign uio_out = {4'h0, r_ack};
    assign uio_oe  = 8'h0F;

endmodule
